// File: rtl/cmd_fetch_pkg.sv
// cmd_fetch_pkg: shared types and helpers for the command fetch sequencer.
//   state_e : fetch FSM states (IDLE, RUN, DONE)
//   sat_inc : saturating increment for counters up to 64 bits wide
package cmd_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Increment value, saturating at the all-ones pattern of the given width.
    // Callers cast their counter up to 64 bits and the result back down.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] all_ones;
        all_ones = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= all_ones) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/cmd_fetch.sv
// cmd_fetch: command memory sequencer for one processor core.
//   Drives the read address of a synchronous-read command memory, holds the
//   program counter and presents one command per cycle to the core decoder.
//   Also arbitrates the memory write port: the host may load programs only
//   while the core is not executing.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, start_addr            begin/restart execution at start_addr
//   halt, jump_en, jump_addr     core control: stop, redirect
//   cmd_out/cmd_addr/cmd_valid   command to the core, cmd_ready accepts it
//   done, wr_err, instr_count    status: finished, dropped host write, retired count
//   mem_read_addr, mem_cmd       memory read port (data one cycle after address)
//   host_we/addr/data            host load port
//   mem_we/waddr/wdata           memory write port
//   fsm_state                    current FSM state, for observation
//
// Handshake: a command retires in any cycle where cmd_valid and cmd_ready are
// both high; cmd_out/cmd_addr stay stable while cmd_valid is high and
// cmd_ready is low, unless the core itself redirects with halt or jump_en.
module cmd_fetch
    import cmd_fetch_pkg::*;
#(
    parameter int CMD_WIDTH  = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  halt,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [CMD_WIDTH-1:0]  cmd_out,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  done,
    output logic                  wr_err,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [CMD_WIDTH-1:0]  mem_cmd,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [CMD_WIDTH-1:0]  host_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [CMD_WIDTH-1:0]  mem_wdata,
    output logic [1:0]            fsm_state
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  handshake;
    logic                  pc_last;
    logic                  begin_run;

    assign handshake = (state == S_RUN) && cmd_ready;
    assign pc_last   = &pc;
    assign begin_run = start && (state != S_RUN);

    // Next pc is also the next read address: the memory registers it on the
    // same edge that updates pc, so the matching command lands with no bubble.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            S_RUN: begin
                if (halt) begin
                    state_next = S_DONE;
                end else if (jump_en) begin
                    pc_next = jump_addr;
                end else if (handshake) begin
                    if (pc_last) begin
                        state_next = S_DONE;   // top of memory: stop, never wrap
                    end else begin
                        pc_next = pc + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_next = S_RUN;
                    pc_next    = start_addr;
                end
            end
        endcase
    end

    always_comb begin
        mem_read_addr = pc_next;
        // IDLE keeps the entry address on the read port even without start.
        if (state == S_IDLE) begin
            mem_read_addr = start_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_count <= '0;
            wr_err      <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (begin_run) begin
                instr_count <= '0;
                wr_err      <= 1'b0;
            end else begin
                if (handshake) begin
                    instr_count <= CNT_WIDTH'(sat_inc(64'(instr_count), CNT_WIDTH));
                end
                if ((state == S_RUN) && host_we) begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    assign cmd_out   = mem_cmd;
    assign cmd_addr  = pc;
    assign cmd_valid = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign fsm_state = state;

    // Host writes pass straight through unless the core is executing.
    assign mem_we    = host_we && (state != S_RUN);
    assign mem_waddr = host_addr;
    assign mem_wdata = host_data;

endmodule

// File: tb/tb_cmd_fetch.sv
// tb_cmd_fetch: directed self-checking bench for cmd_fetch with a behavioural
// synchronous-read command memory attached to the read and write ports.
module tb_cmd_fetch;
    import cmd_fetch_pkg::*;

    localparam int CW = 128;
    localparam int AW = 8;
    localparam int NW = 32;

    localparam logic [CW-1:0] CMD_A   = 128'hA000_0000_0000_0000_0000_0000_0000_000A;
    localparam logic [CW-1:0] CMD_B   = 128'hB000_0000_0000_0000_0000_0000_0000_000B;
    localparam logic [CW-1:0] CMD_C   = 128'hC000_0000_0000_0000_0000_0000_0000_000C;
    localparam logic [CW-1:0] CMD_D   = 128'hD000_0000_0000_0000_0000_0000_0000_000D;
    localparam logic [CW-1:0] CMD_E   = 128'hE000_0000_0000_0000_0000_0000_0000_000E;
    localparam logic [CW-1:0] CMD_10  = 128'h1010_1010_0000_0000_0000_0000_0000_0010;
    localparam logic [CW-1:0] CMD_11  = 128'h1111_1111_0000_0000_0000_0000_0000_0011;
    localparam logic [CW-1:0] CMD_FE  = 128'hFEFE_FEFE_0000_0000_0000_0000_0000_00FE;
    localparam logic [CW-1:0] CMD_FF  = 128'hFFFF_FFFF_0000_0000_0000_0000_0000_00FF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          halt;
    logic          jump_en;
    logic [AW-1:0] jump_addr;
    logic [CW-1:0] cmd_out;
    logic [AW-1:0] cmd_addr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          done;
    logic          wr_err;
    logic [NW-1:0] instr_count;
    logic [AW-1:0] mem_read_addr;
    logic [CW-1:0] mem_cmd;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [CW-1:0] host_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [CW-1:0] mem_wdata;
    logic [1:0]    fsm_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    cmd_fetch #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .CNT_WIDTH(NW)) dut (
        .clk(clk), .reset(reset),
        .start(start), .start_addr(start_addr),
        .halt(halt), .jump_en(jump_en), .jump_addr(jump_addr),
        .cmd_out(cmd_out), .cmd_addr(cmd_addr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .done(done), .wr_err(wr_err), .instr_count(instr_count),
        .mem_read_addr(mem_read_addr), .mem_cmd(mem_cmd),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .fsm_state(fsm_state)
    );

    // ---------------- command memory model ----------------
    logic [CW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_cmd <= mem[mem_read_addr];
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
        host_we = 1'b1; host_addr = a; host_data = d;
        step();
        host_we = 1'b0;
    endtask

    logic [CW-1:0] seq_cmds [4];

    // ---------------- directed sequence ----------------
    initial begin
        seq_cmds[0] = CMD_A; seq_cmds[1] = CMD_B; seq_cmds[2] = CMD_C; seq_cmds[3] = CMD_D;
        reset = 1'b1; start = 1'b0; start_addr = '0; halt = 1'b0; jump_en = 1'b0;
        jump_addr = '0; cmd_ready = 1'b0; host_we = 1'b0; host_addr = '0; host_data = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_valid", cmd_valid, 0);
        check("rst_done", done, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_count", instr_count, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_state", fsm_state, IDLE);

        // Load program in IDLE; write port passes through.
        host_we = 1'b1; host_addr = 8'h00; host_data = CMD_A;
        #1;
        check("idle_mem_we", mem_we, 1);
        check("idle_waddr", mem_waddr, 8'h00);
        step();
        host_write(8'h01, CMD_B);
        host_write(8'h02, CMD_C);
        host_write(8'h03, CMD_D);
        host_write(8'h10, CMD_10);
        host_write(8'h11, CMD_11);
        host_write(8'hFE, CMD_FE);
        host_write(8'hFF, CMD_FF);

        // Sequential fetch, always ready.
        start = 1'b1; start_addr = 8'h00; cmd_ready = 1'b1;
        #1;
        check("idle_rd_addr", mem_read_addr, 8'h00);
        step();
        start = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("seq_valid", cmd_valid, 1);
            check("seq_cmd", cmd_out, seq_cmds[i]);
            check("seq_addr", cmd_addr, AW'(i));
            step();
        end
        cmd_ready = 1'b0; halt = 1'b1;
        #1;
        check("seq_count", instr_count, 4);
        check("seq_addr4", cmd_addr, 8'h04);
        step();
        halt = 1'b0;
        #1;
        check("halt_done", done, 1);
        check("halt_valid", cmd_valid, 0);
        check("halt_count", instr_count, 4);

        // Restart from DONE, stall on B.
        start = 1'b1; start_addr = 8'h00; cmd_ready = 1'b1;
        #1;
        step();
        start = 1'b0;
        #1;
        check("rs_cmd_a", cmd_out, CMD_A);
        step();
        cmd_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_cmd", cmd_out, CMD_B);
            check("stall_addr", cmd_addr, 8'h01);
            check("stall_rd_addr", mem_read_addr, 8'h01);
            check("stall_count", instr_count, 1);
            step();
        end
        cmd_ready = 1'b1;
        #1;
        step();

        // Jump from addr 2 without handshake: C discarded.
        cmd_ready = 1'b0; jump_en = 1'b1; jump_addr = 8'h10;
        #1;
        check("jmp_cur_cmd", cmd_out, CMD_C);
        check("jmp_rd_addr", mem_read_addr, 8'h10);
        step();
        jump_en = 1'b0;
        #1;
        check("jmp_addr", cmd_addr, 8'h10);
        check("jmp_cmd", cmd_out, CMD_10);
        check("jmp_count_nohs", instr_count, 2);

        // Back to 2 (no handshake), then jump again with handshake: C counted.
        jump_en = 1'b1; jump_addr = 8'h02;
        #1;
        step();
        jump_en = 1'b0;
        #1;
        check("jmp2_addr", cmd_addr, 8'h02);
        check("jmp2_cmd", cmd_out, CMD_C);
        check("jmp2_count", instr_count, 2);
        jump_en = 1'b1; jump_addr = 8'h10; cmd_ready = 1'b1;
        #1;
        step();
        jump_en = 1'b0; cmd_ready = 1'b0;
        #1;
        check("jmp3_addr", cmd_addr, 8'h10);
        check("jmp3_cmd", cmd_out, CMD_10);
        check("jmp3_count_hs", instr_count, 3);

        // Halt together with a handshake: still retires, pc held.
        halt = 1'b1; cmd_ready = 1'b1;
        #1;
        step();
        halt = 1'b0; cmd_ready = 1'b0;
        #1;
        check("hhs_done", done, 1);
        check("hhs_count", instr_count, 4);
        check("hhs_addr", cmd_addr, 8'h10);

        // Top-of-memory stop and host write during RUN.
        start = 1'b1; start_addr = 8'hFE; cmd_ready = 1'b1;
        #1;
        step();
        start = 1'b0; host_we = 1'b1; host_addr = 8'h05; host_data = CMD_E;
        #1;
        check("top_addr_fe", cmd_addr, 8'hFE);
        check("top_cmd_fe", cmd_out, CMD_FE);
        check("run_mem_we", mem_we, 0);
        step();
        host_we = 1'b0;
        #1;
        check("top_addr_ff", cmd_addr, 8'hFF);
        check("top_cmd_ff", cmd_out, CMD_FF);
        check("run_wr_err", wr_err, 1);
        step();
        check("top_done", done, 1);
        check("top_valid", cmd_valid, 0);
        check("top_count", instr_count, 2);
        check("top_nowrap", cmd_addr, 8'hFF);
        cmd_ready = 1'b0;

        // After halt, host writes pass; wr_err stays until next start.
        host_we = 1'b1; host_addr = 8'h05; host_data = CMD_E;
        #1;
        check("done_mem_we", mem_we, 1);
        check("done_waddr", mem_waddr, 8'h05);
        check("done_wdata", mem_wdata, CMD_E);
        step();
        host_we = 1'b0;
        #1;
        check("done_wr_err", wr_err, 1);
        start = 1'b1; start_addr = 8'h11;
        #1;
        step();
        start = 1'b0;
        #1;
        check("start_clr_err", wr_err, 0);
        check("start_count0", instr_count, 0);
        check("start_cmd_11", cmd_out, CMD_11);

        // Reset mid-RUN with handshake and jump active.
        host_we = 1'b1;
        #1;
        step();
        host_we = 1'b0;
        #1;
        check("pre_rst_err", wr_err, 1);
        cmd_ready = 1'b1; jump_en = 1'b1; jump_addr = 8'h03; reset = 1'b1;
        #1;
        step();
        reset = 1'b0; jump_en = 1'b0; cmd_ready = 1'b0;
        #1;
        check("mrst_state", fsm_state, IDLE);
        check("mrst_valid", cmd_valid, 0);
        check("mrst_done", done, 0);
        check("mrst_wr_err", wr_err, 0);
        check("mrst_count", instr_count, 0);
        check("mrst_cmd_addr", cmd_addr, 0);
        check("mrst_mem_we", mem_we, 0);
        check("mrst_rd_addr", mem_read_addr, 8'h11);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cmd_fetch.md
# cmd_fetch

Sequencer for the processor's command memory: owns the synchronous-read port, drives a program counter, and presents one command per cycle to the core over a valid/ready handshake with no bubbles on sequential fetch or jump. Also arbitrates the memory write port so the host loads programs only while the core is not executing. Sits between the command memory and the core decoder, one instance per processor core.

## Interface
- CMD_WIDTH, 128, command word width
- ADDR_WIDTH, 8, command memory address width (depth 2**ADDR_WIDTH)
- CNT_WIDTH, 32, retired-command counter width

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin or restart execution at start_addr
- start_addr  in  ADDR_WIDTH  entry address, sampled with start
- halt  in  1  core requests stop (end-of-program command)
- jump_en  in  1  core redirect request
- jump_addr  in  ADDR_WIDTH  redirect target
- cmd_out  out  CMD_WIDTH  current command, equals mem_cmd
- cmd_addr  out  ADDR_WIDTH  address of cmd_out
- cmd_valid  out  1  cmd_out valid
- cmd_ready  in  1  core accepts cmd_out
- done  out  1  execution finished
- wr_err  out  1  sticky: host write dropped during RUN
- instr_count  out  CNT_WIDTH  commands retired since last start
- mem_read_addr  out  ADDR_WIDTH  to memory read address (registered inside memory)
- mem_cmd  in  CMD_WIDTH  memory read data, valid 1 cycle after address
- host_we, host_addr, host_data  in  1/ADDR_WIDTH/CMD_WIDTH  host load port
- mem_we, mem_waddr, mem_wdata  out  1/ADDR_WIDTH/CMD_WIDTH  memory write port

## Operation
- States IDLE, RUN, DONE; reset -> IDLE.
- IDLE: mem_read_addr = start_addr; start -> RUN, pc <= start_addr, instr_count <= 0, wr_err <= 0.
- RUN: cmd_valid = 1, cmd_addr = pc. Next address (combinational onto mem_read_addr), priority high to low:
  - halt: -> DONE, pc held; a simultaneous handshake still retires (counted).
  - jump_en: pc <= jump_addr; current command discarded if not handshaken, retired if handshaken.
  - handshake (cmd_valid & cmd_ready): pc <= pc+1; if pc == 2**ADDR_WIDTH-1, -> DONE (no wrap), pc held.
  - otherwise: pc held, mem_read_addr = pc (output stable under stall).
- DONE: done = 1, cmd_valid = 0, mem_read_addr = pc; start -> RUN exactly as from IDLE.
- start during RUN: ignored.
- Write arbitration: in IDLE/DONE, mem_we/mem_waddr/mem_wdata = host_* combinationally. In RUN, mem_we = 0; host_we sets wr_err (sticky until start or reset).
- instr_count: +1 per handshake in RUN, saturates at all-ones.

## Timing
- Reset values: cmd_valid 0, done 0, wr_err 0, instr_count 0, cmd_addr 0, mem_we 0, pc 0.
- start at edge N -> cmd_valid = 1 in cycle N+1 with cmd_out = mem[start_addr].
- Sequential: handshake in cycle k -> mem[pc+1] presented in cycle k+1 (1 command/cycle sustained).
- Jump in cycle k -> mem[jump_addr] valid in cycle k+1; zero bubble.
- halt in cycle k -> done = 1, cmd_valid = 0 from cycle k+1.
- Reset in any state overrides all inputs that cycle; next cycle is IDLE.

## Structure
- Package cmd_fetch_pkg: state enum (IDLE, RUN, DONE) and a saturating-increment function reusable by other counters.
- No sub-module; the command memory is instantiated beside this block in the core wrapper, not inside it.

## Test plan
- Load mem[0..3] = A,B,C,D in IDLE, start with start_addr=0, cmd_ready=1 -> A,B,C,D on consecutive cycles, cmd_addr 0..3, instr_count 4.
- Stall: cmd_ready=0 for 3 cycles on B -> cmd_out stays B, cmd_addr 1, mem_read_addr 1, instr_count unchanged.
- Jump at addr 2 to 0x10 with cmd_ready=0 -> next cycle cmd_addr 0x10, C not counted; repeat with cmd_ready=1 -> C counted.
- start_addr=0xFE, always ready -> commands at 0xFE, 0xFF, then done=1, cmd_valid=0, instr_count 2, no wrap to 0.
- host_we during RUN -> mem_we stays 0, wr_err=1; after halt, host write passes through; next start clears wr_err.
- Reset asserted mid-RUN with handshake and jump active -> next cycle IDLE, all outputs at reset values.
